rfid_uid_auth: RTL and testbench

RFID_UID_AUTH -- requirements
Module: rfid_uid_auth

---
 rtl/rfid_pkg.sv | 18 +
 rtl/rfid_uid_table.sv | 26 ++
 rtl/rfid_uid_auth.sv | 169 ++++++++++++++++
 tb/tb_rfid_uid_auth.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rfid_pkg.sv
// Shared types and defaults for the RFID UID authentication block.
package rfid_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        RESULT  = 2'd2,
        LOCKOUT = 2'd3
    } rfid_state_t;

    localparam int          UID_BITS_DEF   = 32;
    localparam logic [31:0] MASTER_UID_DEF = 32'hDEADBEEF;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rfid_uid_table.sv
// Enrolled-UID slot storage: one write port, one combinational indexed read.
module rfid_uid_table #(
    parameter int BITS  = 32,
    parameter int SLOTS = 4,
    parameter int AW    = 2
) (
    input  logic            clk_system,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [BITS-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [BITS-1:0] rd_data
);

    // Contents are never reset; table_count gates their visibility.
    logic [BITS-1:0] mem [SLOTS];

    always_ff @(posedge clk_system) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rfid_uid_auth.sv
// RFID UID enroll/verify engine with failure lockout.
// Optional master UID bypass: define RFID_UID_AUTH_MASTER_EN.
import rfid_pkg::*;

module rfid_uid_auth #(
    parameter int BITS           = UID_BITS_DEF,
    parameter int SLOTS          = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000
`ifdef RFID_UID_AUTH_MASTER_EN
    ,
    parameter logic [BITS-1:0] MASTER_UID = BITS'(MASTER_UID_DEF)
`endif
) (
    input  logic                       clk_system,
    input  logic                       reset_system,
    input  logic                       uid_valid,
    input  logic [BITS-1:0]            uid,
    output logic                       uid_ready,
    input  logic                       enroll_mode,
    input  logic                       clear_table,
    output logic                       result_valid,
    output logic                       result_ok,
    output logic                       locked,
    output logic [$clog2(SLOTS+1)-1:0] table_count
);

    localparam int CW = $clog2(SLOTS + 1);
    localparam int AW = addr_w(SLOTS);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    rfid_state_t     state, state_n;
    logic [AW-1:0]   idx, idx_n;
    logic [BITS-1:0] uid_q, uid_n;
    logic            enr_q, enr_n;
    logic            ok_q, ok_n;
    logic [FW-1:0]   fail_cnt, fail_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [LW-1:0]   lk_cnt, lk_n;

    logic            wr_en;
    logic [BITS-1:0] rd_uid;
    logic            slot_hit;
    logic            master_hit;
    logic            hit;
    logic            last;

    rfid_uid_table #(
        .BITS  (BITS),
        .SLOTS (SLOTS),
        .AW    (AW)
    ) u_table (
        .clk_system (clk_system),
        .wr_en      (wr_en),
        .wr_addr    (AW'(cnt_q)),
        .wr_data    (uid_q),
        .rd_addr    (idx),
        .rd_data    (rd_uid)
    );

    assign slot_hit = (CW'(idx) < cnt_q) && (rd_uid == uid_q);
    // Also covers the empty table: one SCAN cycle, then RESULT.
    assign last     = (CW'(idx) + CW'(1)) >= cnt_q;

`ifdef RFID_UID_AUTH_MASTER_EN
    assign master_hit = !enr_q && (idx == '0) && (uid_q == MASTER_UID);
`else
    assign master_hit = 1'b0;
`endif

    assign hit = slot_hit || master_hit;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        uid_n   = uid_q;
        enr_n   = enr_q;
        ok_n    = ok_q;
        fail_n  = fail_cnt;
        cnt_n   = cnt_q;
        lk_n    = lk_cnt;
        wr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (uid_valid) begin
                    uid_n   = uid;
                    enr_n   = enroll_mode;
                    idx_n   = '0;
                    state_n = SCAN;
                end else if (clear_table) begin
                    cnt_n = '0;
                end
            end
            SCAN: begin
                if (hit || last) begin
                    state_n = RESULT;
                    idx_n   = '0;
                    if (enr_q) begin
                        if (hit) begin
                            ok_n = 1'b1;
                        end else if (cnt_q < CW'(SLOTS)) begin
                            wr_en = 1'b1;
                            cnt_n = cnt_q + CW'(1);
                            ok_n  = 1'b1;
                        end else begin
                            ok_n = 1'b0;
                        end
                    end else if (hit) begin
                        ok_n   = 1'b1;
                        fail_n = '0;
                    end else begin
                        ok_n   = 1'b0;
                        fail_n = fail_cnt + FW'(1);
                    end
                end else begin
                    idx_n = idx + AW'(1);
                end
            end
            RESULT: begin
                if (fail_cnt >= FW'(MAX_FAILS)) begin
                    state_n = LOCKOUT;
                    lk_n    = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            LOCKOUT: begin
                if (lk_cnt == LW'(LOCKOUT_CYCLES - 1)) begin
                    state_n = IDLE;
                    fail_n  = '0;
                    lk_n    = '0;
                end else begin
                    lk_n = lk_cnt + LW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_system) begin
        if (!reset_system) begin
            state    <= IDLE;
            idx      <= '0;
            uid_q    <= '0;
            enr_q    <= 1'b0;
            ok_q     <= 1'b0;
            fail_cnt <= '0;
            cnt_q    <= '0;
            lk_cnt   <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            uid_q    <= uid_n;
            enr_q    <= enr_n;
            ok_q     <= ok_n;
            fail_cnt <= fail_n;
            cnt_q    <= cnt_n;
            lk_cnt   <= lk_n;
        end
    end

    assign uid_ready    = (state == IDLE);
    assign result_valid = (state == RESULT);
    assign result_ok    = (state == RESULT) && ok_q;
    assign locked       = (state == LOCKOUT);
    assign table_count  = cnt_q;

endmodule

// File: tb/tb_rfid_uid_auth.sv
// Directed bench for rfid_uid_auth (SLOTS=4, MAX_FAILS=3, LOCKOUT_CYCLES=8).
module tb_rfid_uid_auth;

    logic        clk_system = 1'b0;
    logic        reset_system;
    logic        uid_valid;
    logic [31:0] uid;
    logic        uid_ready;
    logic        enroll_mode;
    logic        clear_table;
    logic        result_valid;
    logic        result_ok;
    logic        locked;
    logic [2:0]  table_count;

    int errors = 0;
    int checks = 0;
    int lat;
    logic ok;
    logic master_exp;

    rfid_uid_auth #(
        .BITS           (32),
        .SLOTS          (4),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clk_system   (clk_system),
        .reset_system (reset_system),
        .uid_valid    (uid_valid),
        .uid          (uid),
        .uid_ready    (uid_ready),
        .enroll_mode  (enroll_mode),
        .clear_table  (clear_table),
        .result_valid (result_valid),
        .result_ok    (result_ok),
        .locked       (locked),
        .table_count  (table_count)
    );

    always #5 clk_system = ~clk_system;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_system);
        #1;
    endtask

    // Present one UID; return cycles from acceptance edge to result_valid.
    task automatic run(input logic [31:0] u, input logic enr,
                       output int l, output logic r_ok);
        uid_valid   = 1'b1;
        uid         = u;
        enroll_mode = enr;
        tick();
        uid_valid = 1'b0;
        l = 1;
        while (!result_valid && l < 30) begin
            tick();
            l++;
        end
        r_ok = result_ok;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_system = 1'b0;
        uid_valid    = 1'b0;
        uid          = '0;
        enroll_mode  = 1'b0;
        clear_table  = 1'b0;
        tick();
        tick();
        reset_system = 1'b1;
        chk("rst_ready", uid_ready, 1);
        chk("rst_count", table_count, 0);
        chk("rst_locked", locked, 0);
        chk("rst_rv", result_valid, 0);
        tick();

        // Enroll into empty table, then verify it.
        run(32'h11223344, 1'b1, lat, ok);
        chk("enr1_lat", lat, 2);
        chk("enr1_ok", ok, 1);
        chk("enr1_cnt", table_count, 1);
        tick();
        chk("enr1_idle", uid_ready, 1);
        run(32'h11223344, 1'b0, lat, ok);
        chk("ver1_lat", lat, 2);
        chk("ver1_ok", ok, 1);
        tick();

        // Clear, then fill the table.
        clear_table = 1'b1;
        tick();
        clear_table = 1'b0;
        chk("clr_cnt", table_count, 0);
        run(32'h000000A1, 1'b1, lat, ok);
        chk("fill0_lat", lat, 2);
        tick();
        run(32'h000000B2, 1'b1, lat, ok);
        chk("fill1_lat", lat, 2);
        tick();
        run(32'h000000C3, 1'b1, lat, ok);
        chk("fill2_lat", lat, 3);
        tick();
        run(32'h000000D4, 1'b1, lat, ok);
        chk("fill3_lat", lat, 4);
        chk("fill3_ok", ok, 1);
        tick();
        chk("full_cnt", table_count, 4);
        run(32'hAAAA5555, 1'b1, lat, ok);
        chk("ovf_lat", lat, 5);
        chk("ovf_ok", ok, 0);
        tick();
        chk("ovf_cnt", table_count, 4);
        run(32'h000000B2, 1'b1, lat, ok);
        chk("dup_ok", ok, 1);
        tick();
        chk("dup_cnt", table_count, 4);
        run(32'h000000D4, 1'b0, lat, ok);
        chk("ver4_lat", lat, 5);
        chk("ver4_ok", ok, 1);
        tick();
        run(32'h000000A1, 1'b0, lat, ok);
        chk("verA_lat", lat, 2);
        chk("verA_ok", ok, 1);
        tick();

        // Three failures -> lockout of 8 cycles.
        for (int i = 0; i < 3; i++) begin
            run(32'h0BADF00D, 1'b0, lat, ok);
            chk("bad_lat", lat, 5);
            chk("bad_ok", ok, 0);
            tick();
            if (i < 2) begin
                chk("bad_nolock", locked, 0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            chk("lk_on", locked, 1);
            chk("lk_rdy", uid_ready, 0);
            uid_valid = (i < 7) && (i % 2 == 0);
            uid       = 32'h000000A1;
            tick();
        end
        uid_valid = 1'b0;
        chk("lk_off", locked, 0);
        chk("lk_idle", uid_ready, 1);
        tick();
        chk("lk_noq", result_valid, 0);

        // F,F,S,F,F must not lock (counter cleared after lockout and on success).
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                run(32'h000000C3, 1'b0, lat, ok);
                chk("mix_ok", ok, 1);
            end else begin
                run(32'h0BADF00D, 1'b0, lat, ok);
                chk("mix_bad", ok, 0);
            end
            tick();
            chk("mix_nolock", locked, 0);
        end

        // Reset in the middle of a scan.
        uid_valid   = 1'b1;
        uid         = 32'h0BADF00D;
        enroll_mode = 1'b0;
        tick();
        uid_valid = 1'b0;
        tick();
        chk("mid_scan", uid_ready, 0);
        reset_system = 1'b0;
        tick();
        reset_system = 1'b1;
        chk("mrst_rdy", uid_ready, 1);
        chk("mrst_cnt", table_count, 0);
        chk("mrst_rv", result_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mrst_quiet", result_valid, 0);
        end

        // Master UID with empty table.
`ifdef RFID_UID_AUTH_MASTER_EN
        master_exp = 1'b1;
`else
        master_exp = 1'b0;
`endif
        run(32'hDEADBEEF, 1'b0, lat, ok);
        chk("mst_lat", lat, 2);
        chk("mst_ok", ok, master_exp);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
